// File: rtl/hash_result_scanner_pkg.sv
// Shared definitions for the hash result scanner: scan FSM encoding,
// memory read latency, summary size and the running-result record.
package hash_result_scanner_pkg;

    localparam int MEM_RD_LAT         = 2;
    localparam int SUMMARY_WORDS      = 2;
    localparam int DEFAULT_NUM_NONCES = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WR0   = 3'd3,
        ST_WR1   = 3'd4,
        ST_DONE  = 3'd5
    } scan_state_t;

    typedef struct packed {
        logic [31:0] min_hash;
        logic [15:0] min_nonce;
        logic        hit;
        logic [15:0] hit_nonce;
    } scan_result_t;

endpackage

// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES H0 words from the shared memory, tracks the minimum hash
// and the first nonce under target, then writes a 2-word summary.
module hash_result_scanner
    import hash_result_scanner_pkg::*;
#(
    parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [15:0] summary_addr,
    input  logic [31:0] target,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        done,
    output logic [31:0] min_hash,
    output logic [15:0] min_nonce,
    output logic        hit,
    output logic [15:0] hit_nonce
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);
    localparam logic [15:0] SUM_HI   = 16'(SUMMARY_WORDS - 1);
    localparam scan_result_t RES_INIT = '{min_hash: 32'hFFFF_FFFF, min_nonce: 16'd0,
                                          hit: 1'b0, hit_nonce: 16'd0};

    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [15:0]               r_result_addr;
    logic [15:0]               r_summary_addr;
    logic [31:0]               r_target;
    logic [15:0]               r_issue_cnt;
    logic [15:0]               r_cap_cnt;
    logic [MEM_RD_LAT-1:0]     r_rd_vld;
    scan_result_t              r_res;
    logic                      r_mem_we;
    logic [15:0]               r_mem_addr;
    logic [31:0]               r_mem_wdata;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_issue;
    logic                      w_capture;
    logic                      w_last_cap;
    logic                      w_wr0;
    logic                      w_wr1;
    logic                      w_fin;

    // Strict less-than keeps the lowest index on ties; only the first hit is recorded.
    function automatic scan_result_t f_scan_update(input scan_result_t cur,
                                                   input logic [31:0]  word,
                                                   input logic [31:0]  tgt,
                                                   input logic [15:0]  idx);
        scan_result_t nxt;
        nxt = cur;
        if (word < cur.min_hash) begin
            nxt.min_hash  = word;
            nxt.min_nonce = idx;
        end
        if (!cur.hit && (word < tgt)) begin
            nxt.hit       = 1'b1;
            nxt.hit_nonce = idx;
        end
        return nxt;
    endfunction

    assign mem_clk    = clk;
    assign w_last_cap = r_rd_vld[MEM_RD_LAT-1] && (r_cap_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; DRAIN leaves on the edge that captures the last word
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (r_issue_cnt == LAST_IDX) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_cap) w_state_nxt = ST_WR0;
            ST_WR0:   w_state_nxt = ST_WR1;
            ST_WR1:   w_state_nxt = ST_DONE;
            ST_DONE:  if (start) w_state_nxt = ST_ISSUE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state action strobes for the datapath
    always_comb begin
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_wr0     = 1'b0;
        w_wr1     = 1'b0;
        w_fin     = 1'b0;
        case (r_state)
            ST_IDLE:  w_accept = start;
            ST_ISSUE: begin
                w_issue   = 1'b1;
                w_capture = r_rd_vld[MEM_RD_LAT-1];
            end
            ST_DRAIN: w_capture = r_rd_vld[MEM_RD_LAT-1];
            ST_WR0:   w_wr0 = 1'b1;
            ST_WR1:   w_wr1 = 1'b1;
            ST_DONE:  begin
                w_accept = start;
                w_fin    = !start;
            end
            default:  ;
        endcase
    end

    // Datapath: input latch, read issue, capture/compare and summary writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result_addr  <= 16'd0;
            r_summary_addr <= 16'd0;
            r_target       <= 32'd0;
            r_issue_cnt    <= 16'd0;
            r_cap_cnt      <= 16'd0;
            r_rd_vld       <= '0;
            r_res          <= RES_INIT;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 16'd0;
            r_mem_wdata    <= 32'd0;
            r_done         <= 1'b0;
        end else if (w_accept) begin
            r_result_addr  <= result_addr;
            r_summary_addr <= summary_addr;
            r_target       <= target;
            r_issue_cnt    <= 16'd0;
            r_cap_cnt      <= 16'd0;
            r_rd_vld       <= '0;
            r_res          <= RES_INIT;
            r_mem_we       <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_rd_vld <= {r_rd_vld[MEM_RD_LAT-2:0], w_issue};
            if (w_issue) begin
                r_mem_addr  <= r_result_addr + r_issue_cnt;
                r_issue_cnt <= r_issue_cnt + 16'd1;
            end
            if (w_capture) begin
                r_res     <= f_scan_update(r_res, mem_read_data, r_target, r_cap_cnt);
                r_cap_cnt <= r_cap_cnt + 16'd1;
            end
            if (w_wr0) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_summary_addr;
                r_mem_wdata <= r_res.min_hash;
            end
            if (w_wr1) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_summary_addr + SUM_HI;
                r_mem_wdata <= {r_res.hit, 15'b0, r_res.hit ? r_res.hit_nonce : r_res.min_nonce};
            end
            if (w_fin) begin
                r_mem_we <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign done           = r_done;
    assign min_hash       = r_res.min_hash;
    assign min_nonce      = r_res.min_nonce;
    assign hit            = r_res.hit;
    assign hit_nonce      = r_res.hit_nonce;

endmodule

// File: tb/tb_hash_result_scanner.sv
// Scoreboard bench for hash_result_scanner: expected summary writes and final
// results are queued per scan; a negedge monitor pops and compares them.
module tb_hash_result_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] result_addr;
    logic [15:0] summary_addr;
    logic [31:0] target;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        done;
    logic [31:0] min_hash;
    logic [15:0] min_nonce;
    logic        hit;
    logic [15:0] hit_nonce;

    logic        ld_en;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] mem [0:65535];

    typedef struct {
        logic [31:0] mh;
        logic [15:0] mn;
        logic        h;
        logic [15:0] hn;
    } exp_res_t;

    logic [47:0] q_wr[$];
    exp_res_t    q_res[$];
    int          errors = 0;
    int          checks = 0;
    logic        done_q = 1'b0;

    hash_result_scanner #(.NUM_NONCES(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .result_addr(result_addr), .summary_addr(summary_addr), .target(target),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .done(done), .min_hash(min_hash), .min_nonce(min_nonce),
        .hit(hit), .hit_nonce(hit_nonce)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory: address sampled one edge after the DUT registers it
    always @(posedge mem_clk) begin
        if (ld_en)       mem[ld_addr]  <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every memory write and every done rise is matched against the queues
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            if (q_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_write_data);
            end else begin
                logic [47:0] w;
                w = q_wr.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w[47:32]));
                chk("wr_data", mem_write_data, w[31:0]);
            end
        end
        if (done && !done_q) begin
            if (q_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_res_t e;
                e = q_res.pop_front();
                chk("min_hash", min_hash, e.mh);
                chk("min_nonce", 32'(min_nonce), 32'(e.mn));
                chk("hit", 32'(hit), 32'(e.h));
                chk("hit_nonce", 32'(hit_nonce), 32'(e.hn));
            end
        end
        done_q <= done;
    end

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_min_hash"}, min_hash, 32'hFFFF_FFFF);
        chk({tag, "_min_nonce"}, 32'(min_nonce), 32'd0);
        chk({tag, "_hit"}, 32'(hit), 32'd0);
        chk({tag, "_hit_nonce"}, 32'(hit_nonce), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    endtask

    // Queue expectations, pulse start, then count edges to done (optionally poking start in DRAIN)
    task automatic run_scan(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tgt,
                            input logic [31:0] e_mh, input logic [15:0] e_mn, input logic e_h,
                            input logic [15:0] e_hn, input logic [31:0] e_w1, input bit poke_drain);
        exp_res_t e;
        int cycles;
        e.mh = e_mh; e.mn = e_mn; e.h = e_h; e.hn = e_hn;
        q_wr.push_back({sa, e_mh});
        q_wr.push_back({sa + 16'd1, e_w1});
        q_res.push_back(e);
        @(negedge clk);
        result_addr = ra; summary_addr = sa; target = tgt; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_cleared", 32'(done), 32'd0);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            if (poke_drain && cycles == 16) begin
                result_addr = 16'h0100; summary_addr = 16'h0900; target = 32'hFFFF_FFFF;
                start = 1'b1;
            end
            @(posedge clk);
            cycles++;
            #1 start = 1'b0;
        end
        chk("latency", 32'(cycles), 32'd21);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0;
        result_addr = 16'd0; summary_addr = 16'd0; target = 32'd0;
        ld_en = 1'b0; ld_addr = 16'd0; ld_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("rst");

        for (int i = 0; i < 16; i++) begin
            load(16'h0100 + 16'(i), 32'h10 + 32'(i));
            load(16'h0300 + 16'(i), 32'hFFFF_FFFF);
            load(16'h0500 + 16'(i), (i == 5 || i == 9) ? 32'h3 : 32'h8000_0000);
            load(16'hFFF8 + 16'(i), (i == 3) ? 32'h200 : (i == 10) ? 32'h100 : (32'h7000_0000 | 32'(i)));
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ascending hashes, first word already under target
        run_scan(16'h0100, 16'h0200, 32'h12, 32'h10, 16'd0, 1'b1, 16'd0, 32'h8000_0000, 1'b0);
        // All-ones: nothing is strictly below, min stays at its initial value
        run_scan(16'h0300, 16'h0400, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 1'b0, 16'd0, 32'h0, 1'b0);
        // Tie at indices 5 and 9: lowest index wins
        run_scan(16'h0500, 16'h0600, 32'h4, 32'h3, 16'd5, 1'b1, 16'd5, 32'h8000_0005, 1'b0);
        // Reads wrap past 0xFFFF; first hit (3) precedes the minimum (10); summary+1 wraps to 0
        run_scan(16'hFFF8, 16'hFFFF, 32'h300, 32'h100, 16'd10, 1'b1, 16'd3, 32'h8000_0003, 1'b0);

        // Reset during issue of index 7: everything back to reset values, no summary
        @(negedge clk);
        result_addr = 16'h0100; summary_addr = 16'h0A00; target = 32'h20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        // Target equal to the smallest word: strict compare gives no hit
        run_scan(16'h0100, 16'h0700, 32'h10, 32'h10, 16'd0, 1'b0, 16'd0, 32'h0, 1'b0);

        // start during DRAIN is ignored; target 0 never hits
        run_scan(16'h0500, 16'h0800, 32'h0, 32'h3, 16'd5, 1'b0, 16'd0, 32'h5, 1'b1);
        // Restart straight from DONE with a new target
        run_scan(16'h0500, 16'h0B00, 32'h8000_0001, 32'h3, 16'd5, 1'b1, 16'd0, 32'h8000_0000, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", 32'(q_wr.size()), 32'd0);
        chk("pending_results", 32'(q_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
